rf_wb_scheduler: RTL
====================

Name: rf_wb_scheduler

Overview:
- Write-port arbiter and register scoreboard for the 32-entry register file.
- Shares the single register-file write port between two writeback requesters: ALU (EX result) and LSU (load data, variable latency). Round-robin arbitration with valid/ready handshakes.
- Tracks destination registers with writes still pending and stalls issue on RAW/WAW hazards.
- Sits between decode/issue, the EX/LSU units and the register file's wr_en/a3/din port.

Parameters:
- D_WIDTH, 32, data width of the register file and writeback data.
- ADDRESS_WIDTH, 5, register index width; the scoreboard has 2**ADDRESS_WIDTH entries.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decode presents an instruction.
- issue_rs1  input  ADDRESS_WIDTH  source register 1.
- issue_rs2  input  ADDRESS_WIDTH  source register 2.
- issue_rd  input  ADDRESS_WIDTH  destination register.
- issue_rd_we  input  1  instruction writes rd.
- issue_stall  output  1  hazard; issue is not accepted this cycle.
- alu_wb_valid  input  1  ALU writeback request.
- alu_wb_rd  input  ADDRESS_WIDTH  ALU destination register.
- alu_wb_data  input  D_WIDTH  ALU result.
- alu_wb_ready  output  1  ALU request granted this cycle.
- lsu_wb_valid  input  1  LSU writeback request.
- lsu_wb_rd  input  ADDRESS_WIDTH  LSU destination register.
- lsu_wb_data  input  D_WIDTH  load data.
- lsu_wb_ready  output  1  LSU request granted this cycle.
- rf_wr_en  output  1  to register file wr_en.
- rf_a3  output  ADDRESS_WIDTH  to register file a3.
- rf_din  output  D_WIDTH  to register file din.
- busy_vec  output  2**ADDRESS_WIDTH  scoreboard contents, for debug.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - busy_vec = 0, rf_wr_en = 0, rf_a3 = 0, rf_din = 0.
  - Round-robin pointer set so the ALU has priority on the first conflict.
- issue_stall (combinational):
  - Asserted when issue_valid && (busy[rs1] || busy[rs2] || (issue_rd_we && busy[rd])).
  - busy[0] is hard-wired to 0.
  - No bypass: stall is computed from the current busy register only.
- Issue accept = issue_valid && !issue_stall. On accept with issue_rd_we && rd != 0, set busy[rd] at the next posedge.
- Arbitration (combinational grant, registered write port):
  - One valid requester: it is granted.
  - Both valid: the requester not granted most recently on a conflict is granted. The pointer updates only on conflict cycles.
  - ready is high only for the granted requester. A transfer completes on valid && ready.
  - Requesters hold valid, rd and data stable until ready.
- Write port, one cycle latency:
  - On a transfer, the next posedge loads rf_a3/rf_din and sets rf_wr_en = (rd != 0).
  - With no transfer, rf_wr_en = 0 the next cycle; rf_a3/rf_din hold their values.
  - The register file commits on the negedge inside the cycle rf_wr_en is high.
- Busy clear:
  - busy[rd] clears on the same posedge that loads the write registers.
  - An instruction issuing in the following cycle reads the register file after the negedge write, so its operands are correct.
- Simultaneous set and clear of the same rd cannot occur: WAW stall blocks issue while busy[rd] is set.
  - Set/clear of different registers in one cycle both take effect.
  - The bench asserts that a writeback to a non-busy rd != 0 never occurs.
- Writeback to rd = 0: accepted (ready given), no register-file write, no scoreboard change.
- Reset mid-operation: all pending busy bits and any in-flight write are dropped. Upstream units are reset by the same rst.

Decomposition:
- Shared package rf_pkg: D_WIDTH/ADDRESS_WIDTH defaults, NUM_REGS constant, wb_req_t struct (valid, rd, data), REQ_ALU/REQ_LSU grant enum.
- One sub-module, rr_arb2: 2-way round-robin arbiter (req[1:0] -> gnt[1:0], pointer flop, async rst).
- Scoreboard and write-port registers stay in rf_wb_scheduler.

Test Plan:
- After reset: issue rs1=5, rs2=6, rd=7, we=1 -> no stall; next cycle busy_vec[7]=1. Issue reading rs1=7 -> issue_stall=1 until ALU writeback rd=7, data=0x1234 transfers. Then rf_wr_en=1, rf_a3=7, rf_din=0x1234 the next cycle, busy[7]=0, stall drops; the stalled instruction reads 0x1234.
- ALU (rd=3, 0xAAAA) and LSU (rd=4, 0x5555) valid together, both busy -> ALU granted first. LSU is granted the next cycle. In the next conflict, LSU wins first.
- Issue rd=0, we=1 -> busy_vec stays 0. LSU writeback rd=0 -> lsu_wb_ready=1, rf_wr_en=0.
- WAW: rd=9 busy; issue another write to rd=9 with non-busy sources -> stall until the writeback of 9 transfers.
- Same cycle: issue sets rd=12 while writeback clears rd=11 -> busy_vec shows only bit 12 afterwards.
- Assert rst asynchronously mid-cycle with busy bits set and rf_wr_en=1 -> busy_vec=0, rf_wr_en=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback scheduler: default widths,
// writeback request record and requester identifiers.
package rf_pkg;

  localparam int DEF_D_WIDTH       = 32;
  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int NUM_REGS          = 2 ** DEF_ADDRESS_WIDTH;

  typedef struct packed {
    logic                         valid;
    logic [DEF_ADDRESS_WIDTH-1:0] rd;
    logic [DEF_D_WIDTH-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves only when both
// requesters contend, so the loser of a conflict wins the next one.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_lsu;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_lsu ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_lsu <= 1'b0;
    end else if (req == 2'b11) begin
      prio_lsu <= gnt[REQ_ALU];
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU/LSU writebacks onto the
// single write port and keeps a busy scoreboard that stalls RAW/WAW hazards.
module rf_wb_scheduler
  import rf_pkg::*;
#(
  parameter int D_WIDTH       = DEF_D_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]  issue_rs1,
  input  logic [ADDRESS_WIDTH-1:0]  issue_rs2,
  input  logic [ADDRESS_WIDTH-1:0]  issue_rd,
  input  logic                      issue_rd_we,
  output logic                      issue_stall,
  input  logic                      alu_wb_valid,
  input  logic [ADDRESS_WIDTH-1:0]  alu_wb_rd,
  input  logic [D_WIDTH-1:0]        alu_wb_data,
  output logic                      alu_wb_ready,
  input  logic                      lsu_wb_valid,
  input  logic [ADDRESS_WIDTH-1:0]  lsu_wb_rd,
  input  logic [D_WIDTH-1:0]        lsu_wb_data,
  output logic                      lsu_wb_ready,
  output logic                      rf_wr_en,
  output logic [ADDRESS_WIDTH-1:0]  rf_a3,
  output logic [D_WIDTH-1:0]        rf_din,
  output logic [2**ADDRESS_WIDTH-1:0] busy_vec
);

  localparam int N = 2 ** ADDRESS_WIDTH;

  logic [N-1:0]             busy_q;
  logic [N-1:0]             busy_nxt;
  logic [1:0]               gnt;
  logic                     xfer;
  logic                     accept;
  logic [ADDRESS_WIDTH-1:0] wb_rd;
  logic [D_WIDTH-1:0]       wb_data;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({lsu_wb_valid, alu_wb_valid}),
    .gnt (gnt)
  );

  assign alu_wb_ready = gnt[REQ_ALU];
  assign lsu_wb_ready = gnt[REQ_LSU];
  assign xfer         = |gnt;
  assign wb_rd        = gnt[REQ_LSU] ? lsu_wb_rd   : alu_wb_rd;
  assign wb_data      = gnt[REQ_LSU] ? lsu_wb_data : alu_wb_data;

  // No bypass from the clearing writeback: the register file is written on the
  // following negedge, so a consumer issuing one cycle later already sees it.
  assign issue_stall = issue_valid &&
                       (busy_q[issue_rs1] || busy_q[issue_rs2] ||
                        (issue_rd_we && busy_q[issue_rd]));
  assign accept      = issue_valid && !issue_stall;

  always_comb begin
    busy_nxt = busy_q;
    if (xfer) begin
      busy_nxt[wb_rd] = 1'b0;
    end
    if (accept && issue_rd_we) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      rf_wr_en <= 1'b0;
      rf_a3    <= '0;
      rf_din   <= '0;
    end else begin
      busy_q   <= busy_nxt;
      rf_wr_en <= xfer && (wb_rd != '0);
      if (xfer) begin
        rf_a3  <= wb_rd;
        rf_din <= wb_data;
      end
    end
  end

  assign busy_vec = busy_q;

endmodule
